// File: rtl/prog_loader.sv
// prog_loader: streams instruction words from a valid/ready host channel into
// the instruction-memory write port, then releases the core via core_start.
// Optional build macro PROG_LOADER_CHECKSUM_EN adds an exp_sum input; the
// running sum of loaded words must match it before the core is released.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no program loaded (reset, abort or checksum failure)
// LOAD   | accepting host words, one memory write per transfer
// FINISH | final write lands; decide success (done) or failure (err)
// RUN    | program loaded, core released; reload allowed
module prog_loader #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_WORDS = 1024,
  parameter int BASE_ADDR = 0,
  parameter int ADDR_STEP = 1,
  parameter int LEN_W     = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic [LEN_W-1:0]  load_len,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
`ifdef PROG_LOADER_CHECKSUM_EN
  input  logic [DATA_W-1:0] exp_sum,
`endif
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              core_start,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FINISH, S_RUN} state_t;

  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] STEP_A = ADDR_W'(ADDR_STEP);
  localparam logic [LEN_W-1:0]  MAX_L  = LEN_W'(MAX_WORDS);

  state_t            state;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt;
  logic              len_ok;
  logic [ADDR_W-1:0] word_addr;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;
  logic [DATA_W-1:0] exp_q;
`endif

  assign len_ok    = (load_len != '0) && (load_len <= MAX_L);
  // Address arithmetic wraps modulo 2^ADDR_W by construction.
  assign word_addr = BASE_A + ADDR_W'(cnt) * STEP_A;
  // Abort suppresses the handshake so a word offered in the abort cycle is never written.
  assign in_ready  = (state == S_LOAD) && !abort;

  // Loader FSM with registered memory-port and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      len_q      <= '0;
      cnt        <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= BASE_A;
      mem_wdata  <= '0;
      core_start <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q      <= '0;
      exp_q      <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      case (state)
        S_IDLE, S_RUN: begin
          if (load_req) begin
            if (len_ok) begin
              state      <= S_LOAD;
              len_q      <= load_len;
              cnt        <= '0;
              core_start <= 1'b0;
              busy       <= 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
              sum_q      <= '0;
              exp_q      <= exp_sum;
`endif
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (abort) begin
            state      <= S_IDLE;
            err        <= 1'b1;
            busy       <= 1'b0;
            core_start <= 1'b0;
          end else if (in_valid) begin
            mem_we    <= 1'b1;
            mem_addr  <= word_addr;
            mem_wdata <= in_data;
            cnt       <= cnt + LEN_W'(1);
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q     <= sum_q + in_data;
`endif
            if (cnt == len_q - LEN_W'(1)) state <= S_FINISH;
          end
        end
        S_FINISH: begin
          if (abort) begin
            state      <= S_IDLE;
            err        <= 1'b1;
            busy       <= 1'b0;
            core_start <= 1'b0;
          end else
`ifdef PROG_LOADER_CHECKSUM_EN
          if (sum_q != exp_q) begin
            state      <= S_IDLE;
            err        <= 1'b1;
            busy       <= 1'b0;
            core_start <= 1'b0;
          end else
`endif
          begin
            state      <= S_RUN;
            done       <= 1'b1;
            busy       <= 1'b0;
            core_start <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: two instances (word and byte addressing)
// share the host stimulus; expectations come from a load-level model.
module tb_prog_loader;
  localparam int AW = 32, DW = 32, LW = 11, MAXW = 1024;

  typedef logic [63:0] q64_t[$];
  typedef logic [DW-1:0] wq_t[$];

  logic clk = 1'b0;
  logic rst;
  logic load_req, abort, in_valid;
  logic [LW-1:0] load_len;
  logic [DW-1:0] in_data;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [DW-1:0] exp_sum;
`endif
  logic rdy1, we1, cs1, busy1, done1, err1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wd1;
  logic rdy4, we4, cs4, busy4, done4, err4;
  logic [AW-1:0] addr4;
  logic [DW-1:0] wd4;

  always #5 clk = ~clk;

  prog_loader #(.ADDR_STEP(1)) u1 (
    .clk(clk), .rst(rst), .load_req(load_req), .load_len(load_len), .abort(abort),
    .in_valid(in_valid), .in_data(in_data),
`ifdef PROG_LOADER_CHECKSUM_EN
    .exp_sum(exp_sum),
`endif
    .in_ready(rdy1), .mem_we(we1), .mem_addr(addr1), .mem_wdata(wd1),
    .core_start(cs1), .busy(busy1), .done(done1), .err(err1));

  prog_loader #(.ADDR_STEP(4)) u4 (
    .clk(clk), .rst(rst), .load_req(load_req), .load_len(load_len), .abort(abort),
    .in_valid(in_valid), .in_data(in_data),
`ifdef PROG_LOADER_CHECKSUM_EN
    .exp_sum(exp_sum),
`endif
    .in_ready(rdy4), .mem_we(we4), .mem_addr(addr4), .mem_wdata(wd4),
    .core_start(cs4), .busy(busy4), .done(done4), .err(err4));

  int checks = 0, errors = 0;
  int cyc = 0, done_n, err_n, lat_bad, rdy_bad, last_we_cyc, done_cyc, timeouts = 0;
  q64_t wq1, wq4;
  // Model: a load is in progress with m_left words still to accept.
  bit m_loading = 0;
  int m_left = 0;

  function automatic q64_t exp_wr(input wq_t w, input int n, input int stp);
    q64_t r;
    for (int i = 0; i < n; i++) r.push_back({32'(i * stp), w[i]});
    return r;
  endfunction

  function automatic wq_t rnd_words(input int n);
    wq_t r;
    for (int i = 0; i < n; i++) r.push_back($urandom);
    return r;
  endfunction

  function automatic logic [DW-1:0] wsum(input wq_t w);
    logic [DW-1:0] s = '0;
    foreach (w[i]) s += w[i];
    return s;
  endfunction

  task automatic clear_obs();
    wq1.delete(); wq4.delete();
    done_n = 0; err_n = 0; lat_bad = 0; rdy_bad = 0; last_we_cyc = -10; done_cyc = -10;
  endtask

  // One clock: records observations and tallies handshake/latency deviations from the model.
  task automatic step();
    bit acc, exp_rdy;
    #1;
    exp_rdy = m_loading && !abort;
    acc = exp_rdy && in_valid;
    if (rdy1 !== exp_rdy || rdy4 !== exp_rdy) rdy_bad++;
    @(posedge clk);
    #1;
    cyc++;
    if (we1 !== acc || we4 !== acc) lat_bad++;
    if (we1) begin wq1.push_back({addr1, wd1}); last_we_cyc = cyc; end
    if (we4) wq4.push_back({addr4, wd4});
    if (done1) begin done_n++; done_cyc = cyc; end
    if (err1) err_n++;
    if (acc) begin
      m_left--;
      if (m_left == 0) m_loading = 0;
    end
  endtask

  task automatic start_load(input int len, input logic [DW-1:0] es);
    load_req = 1'b1;
    load_len = LW'(len);
`ifdef PROG_LOADER_CHECKSUM_EN
    exp_sum = es;
`endif
    step();
    load_req = 1'b0;
    if (!m_loading && len >= 1 && len <= MAXW) begin
      m_loading = 1; m_left = len;
    end
  endtask

  // Offers words with a random valid duty; abort raised while offering word abort_at.
  task automatic feed(input wq_t w, input int pct, input int abort_at);
    int k = 0, guard = 0;
    while (k < w.size()) begin
      if (guard >= 5000) begin timeouts++; break; end
      in_valid = (k == abort_at) || ($urandom_range(99) < pct);
      in_data = in_valid ? w[k] : $urandom;
      abort = (k == abort_at);
      step();
      guard++;
      if (abort) begin abort = 1'b0; m_loading = 0; break; end
      if (in_valid) k++;
    end
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; load_req = 0; load_len = '0; abort = 0; in_valid = 0; in_data = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
    exp_sum = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m_loading = 0; m_left = 0;
  endtask

  task automatic test_reset();
    wq_t w;
    do_reset();
    checks++;
    if ({rdy1, we1, cs1, busy1, done1, err1} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 000000", {rdy1, we1, cs1, busy1, done1, err1});
    end
    checks++;
    if (addr1 !== 32'd0 || wd1 !== 32'd0) begin
      errors++; $display("FAIL reset_mem: addr %h data %h want 0 0", addr1, wd1);
    end
    // Asynchronous reset in the middle of a load, just after a write was issued.
    clear_obs();
    w = rnd_words(4);
    start_load(4, wsum(w));
    in_valid = 1'b1; in_data = w[0];
    step();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({rdy1, we1, busy1, cs1} !== 4'b0 || addr1 !== 32'd0 || wd1 !== 32'd0) begin
      errors++;
      $display("FAIL reset_async: rdy/we/busy/cs %b addr %h data %h want 0000 0 0", {rdy1, we1, busy1, cs1}, addr1, wd1);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    m_loading = 0; m_left = 0;
  endtask

  task automatic test_basic();
    wq_t w = '{32'h11, 32'h22, 32'h33, 32'h44};
    q64_t e1 = exp_wr(w, 4, 1), e4 = exp_wr(w, 4, 4);
    int bad = 0;
    clear_obs();
    start_load(4, wsum(w));
    checks++;
    if (busy1 !== 1'b1 || cs1 !== 1'b0) begin
      errors++; $display("FAIL basic_start: busy %b cs %b want 1 0", busy1, cs1);
    end
    feed(w, 100, -1);
    step();
    if (wq1.size() != 4 || wq4.size() != 4) bad = 1;
    else for (int i = 0; i < 4; i++) if (wq1[i] !== e1[i] || wq4[i] !== e4[i]) bad = 1;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL basic_writes: got %0d/%0d writes or wrong addr/data, want 4 at 0..3 / 0..12", wq1.size(), wq4.size());
    end
    checks++;
    if (lat_bad != 0 || rdy_bad != 0) begin
      errors++; $display("FAIL basic_handshake: latency deviations %0d ready deviations %0d want 0 0", lat_bad, rdy_bad);
    end
    checks++;
    if (done_n != 1 || done_cyc != last_we_cyc + 1) begin
      errors++; $display("FAIL basic_done: %0d pulses at cycle %0d, last write %0d, want 1 at next cycle", done_n, done_cyc, last_we_cyc);
    end
    step();
    checks++;
    if (cs1 !== 1'b1 || busy1 !== 1'b0 || done1 !== 1'b0 || err_n != 0) begin
      errors++; $display("FAIL basic_run: cs %b busy %b done %b errs %0d want 1 0 0 0", cs1, busy1, done1, err_n);
    end
  endtask

  task automatic test_stall();
    bit pat[6] = '{1, 0, 0, 1, 0, 1};
    wq_t w = rnd_words(3);
    q64_t e1 = exp_wr(w, 3, 1);
    int k = 0, bad = 0;
    clear_obs();
    start_load(3, wsum(w));
    foreach (pat[i]) begin
      in_valid = pat[i];
      in_data = pat[i] ? w[k] : $urandom;
      step();
      if (pat[i]) k++;
    end
    in_valid = 1'b0;
    step();
    if (wq1.size() != 3) bad = 1;
    else for (int i = 0; i < 3; i++) if (wq1[i] !== e1[i]) bad = 1;
    checks++;
    if (bad != 0 || lat_bad != 0) begin
      errors++; $display("FAIL stall_writes: %0d writes, %0d latency deviations, want 3 at 0,1,2 and 0", wq1.size(), lat_bad);
    end
    checks++;
    if (done_n != 1 || cs1 !== 1'b1) begin
      errors++; $display("FAIL stall_done: done %0d cs %b want 1 1", done_n, cs1);
    end
  endtask

  task automatic test_reject();
    wq_t w;
    do_reset();
    clear_obs();
    start_load(0, '0);
    checks++;
    if (err_n != 1 || busy1 !== 1'b0 || cs1 !== 1'b0) begin
      errors++; $display("FAIL reject_zero: errs %0d busy %b cs %b want 1 0 0", err_n, busy1, cs1);
    end
    start_load(MAXW + 1, '0);
    step();
    checks++;
    if (err_n != 2 || wq1.size() != 0 || rdy_bad != 0 || rdy1 !== 1'b0 || err1 !== 1'b0) begin
      errors++; $display("FAIL reject_big: errs %0d writes %0d ready %b want 2 0 0", err_n, wq1.size(), rdy1);
    end
    // Largest legal length is accepted.
    clear_obs();
    w = rnd_words(MAXW);
    start_load(MAXW, wsum(w));
    feed(w, 100, -1);
    step();
    checks++;
    if (wq1.size() != MAXW || wq1[MAXW-1] !== {32'(MAXW - 1), w[MAXW-1]} || done_n != 1 || err_n != 0) begin
      errors++; $display("FAIL reject_max: writes %0d done %0d errs %0d want %0d 1 0", wq1.size(), done_n, err_n, MAXW);
    end
  endtask

  task automatic test_abort();
    wq_t w = rnd_words(5);
    q64_t e1 = exp_wr(w, 2, 1);
    clear_obs();
    start_load(5, wsum(w));
    feed(w, 100, 2);
    checks++;
    if (wq1.size() != 2 || wq1[0] !== e1[0] || wq1[1] !== e1[1] || lat_bad != 0) begin
      errors++; $display("FAIL abort_writes: %0d writes, %0d latency deviations, want 2 and 0", wq1.size(), lat_bad);
    end
    checks++;
    if (err_n != 1 || cs1 !== 1'b0 || busy1 !== 1'b0 || rdy1 !== 1'b0 || done_n != 0) begin
      errors++; $display("FAIL abort_state: errs %0d cs %b busy %b rdy %b done %0d want 1 0 0 0 0", err_n, cs1, busy1, rdy1, done_n);
    end
    // Abort during the FINISH cycle prevents release.
    clear_obs();
    w = rnd_words(1);
    start_load(1, wsum(w));
    feed(w, 100, -1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if (wq1.size() != 1 || err_n != 1 || done_n != 0 || cs1 !== 1'b0 || busy1 !== 1'b0) begin
      errors++; $display("FAIL abort_finish: writes %0d errs %0d done %0d cs %b busy %b want 1 1 0 0 0", wq1.size(), err_n, done_n, cs1, busy1);
    end
  endtask

  task automatic test_back_to_back();
    wq_t w = rnd_words(2);
    q64_t e1 = exp_wr(w, 2, 1), e4 = exp_wr(w, 2, 4);
    wq_t w0 = rnd_words(3);
    clear_obs();
    start_load(3, wsum(w0));
    feed(w0, 100, -1);
    step();
    clear_obs();
    abort = 1'b1;
    step();
    abort = 1'b0;
    start_load(0, '0);
    checks++;
    if (err_n != 1 || cs1 !== 1'b1) begin
      errors++; $display("FAIL run_ignore: errs %0d cs %b want 1 1", err_n, cs1);
    end
    start_load(2, wsum(w));
    checks++;
    if (cs1 !== 1'b0 || busy1 !== 1'b1) begin
      errors++; $display("FAIL run_reload: cs %b busy %b want 0 1", cs1, busy1);
    end
    // A second request while busy must not restart the load.
    load_req = 1'b1; load_len = LW'(7);
    in_valid = 1'b1; in_data = w[0];
    step();
    load_req = 1'b0;
    in_data = w[1];
    step();
    in_valid = 1'b0;
    step();
    checks++;
    if (wq1.size() != 2 || wq4.size() != 2 || wq1[0] !== e1[0] || wq1[1] !== e1[1] ||
        wq4[0] !== e4[0] || wq4[1] !== e4[1] || lat_bad != 0) begin
      errors++; $display("FAIL run_writes: %0d/%0d writes, %0d latency deviations, want 2/2 at 0,1 and 0,4", wq1.size(), wq4.size(), lat_bad);
    end
    checks++;
    if (done_n != 1 || cs1 !== 1'b1 || cs4 !== 1'b1 || err_n != 1) begin
      errors++; $display("FAIL run_done: done %0d cs %b/%b errs %0d want 1 1/1 1", done_n, cs1, cs4, err_n);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 25; it++) begin
      int len = $urandom_range(16, 1);
      int ab = ($urandom_range(3) == 0) ? $urandom_range(len - 1, 0) : -1;
      int n = (ab < 0) ? len : ab;
      wq_t w = rnd_words(len);
      q64_t e1 = exp_wr(w, n, 1), e4 = exp_wr(w, n, 4);
      int bad = 0;
      clear_obs();
      start_load(len, wsum(w));
      feed(w, $urandom_range(100, 30), ab);
      if (ab < 0) step();
      if (wq1.size() != n || wq4.size() != n) bad = 1;
      else for (int i = 0; i < n; i++) if (wq1[i] !== e1[i] || wq4[i] !== e4[i]) bad = 1;
      checks++;
      if (bad != 0 || lat_bad != 0 || rdy_bad != 0 || timeouts != 0) begin
        errors++;
        $display("FAIL rand_writes it %0d: %0d writes want %0d, lat %0d rdy %0d timeouts %0d", it, wq1.size(), n, lat_bad, rdy_bad, timeouts);
      end
      checks++;
      if (done_n != ((ab < 0) ? 1 : 0) || err_n != ((ab < 0) ? 0 : 1) || cs1 !== ((ab < 0) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL rand_status it %0d: done %0d err %0d cs %b, abort_at %0d", it, done_n, err_n, cs1, ab);
      end
    end
  endtask

`ifdef PROG_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    wq_t w = '{32'd1, 32'd2, 32'd3};
    clear_obs();
    start_load(3, 32'd6);
    feed(w, 100, -1);
    step();
    checks++;
    if (done_n != 1 || err_n != 0 || cs1 !== 1'b1) begin
      errors++; $display("FAIL sum_match: done %0d err %0d cs %b want 1 0 1", done_n, err_n, cs1);
    end
    clear_obs();
    start_load(3, 32'd7);
    feed(w, 100, -1);
    step();
    checks++;
    if (done_n != 0 || err_n != 1 || cs1 !== 1'b0 || busy1 !== 1'b0) begin
      errors++; $display("FAIL sum_mismatch: done %0d err %0d cs %b busy %b want 0 1 0 0", done_n, err_n, cs1, busy1);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if (err_n != 1 || rdy1 !== 1'b0 || cs1 !== 1'b0) begin
      errors++; $display("FAIL sum_idle: err %0d rdy %b cs %b want 1 0 0", err_n, rdy1, cs1);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_reject();
    test_abort();
    test_back_to_back();
    test_random();
`ifdef PROG_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
